cordic_byte_framer: RTL
=======================

Name: cordic_byte_framer

Overview:
- Parametrised byte-serial framer between the Tiny Tapeout 8-bit pin interface and an iterative CORDIC core.
- Accepts a command byte plus little-endian operand bytes over a valid/ready byte stream, assembles the operands, and launches the core with a start/done handshake.
- Serialises the core's two results back out, LSB first, over a second valid/ready byte stream.
- Supersedes the fixed 16-bit, vectoring-only wrapper protocol: operand/result widths are configurable, a rotation mode is added, and error/timeout reporting is new.

Parameters:
IN_W, 16, width of X and Y operands; multiple of 8, range 8..32
Z_W, 32, width of rotation angle Z; multiple of 8, range 8..32
A_W, 16, width of result A (magnitude, or X'); multiple of 8
B_W, 32, width of result B (phase, or Y'); multiple of 8
TIMEOUT, 255, maximum WAIT cycles before core_done is abandoned; must be ≥1

Ports:
clk  in  1  clock
rst  in  1  reset
in_data  in  8  input byte
in_valid  in  1  input byte valid
in_ready  out  1  framer accepts a byte this cycle
out_data  out  8  output byte
out_valid  out  1  output byte valid
out_ready  in  1  downstream accepts a byte
core_start  out  1  one-cycle launch pulse to core
core_mode  out  1  0 = vectoring, 1 = rotation; stable from START until return to CMD
core_x  out  IN_W  assembled X
core_y  out  IN_W  assembled Y
core_z  out  Z_W  assembled Z; 0 in vectoring mode
core_done  in  1  core result valid, single-cycle
core_a  in  A_W  result A, sampled on core_done
core_b  in  B_W  result B, sampled on core_done
err  out  2  sticky errors: bit0 bad command, bit1 core timeout
err_clr  in  1  clears err; takes priority over a same-cycle set

Behaviour:
- Reset: single clock `clk`; `rst` is synchronous and active-high. On rst, state = CMD; all counters, operand and result registers = 0.
- Output values while rst is high: in_ready = 0, out_valid = 0, out_data = 0, core_start = 0, core_mode = 0, err = 0.
- Reset mid-operation: partial frames and latched results are discarded. A core_done arriving later is ignored.
- in_ready = 1 exactly when state is CMD or RX and rst = 0. A byte is accepted on in_valid & in_ready.
- CMD state:
  - Accepted byte 0x00 → mode 0, go to RX.
  - Accepted byte 0x01 → mode 1, go to RX.
  - Any other value → err[0] set, byte dropped, stay in CMD.
- RX state:
  - Bytes fill X, then Y, then Z (Z only in mode 1). Each operand is little-endian.
  - Byte count is 2·IN_W/8 in mode 0, or 2·IN_W/8 + Z_W/8 in mode 1.
  - Accepting the last byte moves to START on the next edge.
- START state: lasts 1 cycle with core_start = 1. core_x/y/z/mode are already stable. Next state is WAIT; the timeout counter is cleared.
- WAIT state:
  - On core_done = 1: latch core_a and core_b, go to TX.
  - Otherwise the counter increments. When it reaches TIMEOUT without done: set err[1], go to CMD, emit no output.
  - core_done and the timeout in the same cycle: done wins.
- TX state:
  - out_valid = 1. Bytes are sent A LSB→MSB, then B LSB→MSB, for A_W/8 + B_W/8 bytes total.
  - Advance on out_valid & out_ready. out_data holds stable while out_ready = 0.
  - After the last byte is accepted, out_valid drops on the next edge and state returns to CMD.
- Latency:
  - Last input byte accepted at edge N → core_start high in cycle N+1.
  - core_done high in cycle D → out_valid high in cycle D+1.
  - in_ready is 0 from START until back in CMD; there is no overlap between frames.
- core_done outside WAIT is ignored.
- err bits are sticky until err_clr. err_clr and a set in the same cycle → cleared.

Test Plan:
- Vectoring frame:
  - Stimulus: send 00,24,35,81,5E; core model returns A=0x1234, B=0xDEADBEEF 3 cycles after start.
  - Required: core_x=0x3524, core_y=0x5E81, core_z=0, core_mode=0, exactly one core_start pulse.
  - Required output: 34,12,EF,BE,AD,DE, then in_ready=1.
- Rotation frame:
  - Stimulus: send 01,00,40,00,00,00,00,00,20 (X=0x4000, Y=0, Z=0x20000000).
  - Required: core_mode=1, core_z=0x20000000; 6 output bytes match the model.
- Bad command: send 0x82 → err=01, in_ready stays 1. The next valid vectoring frame completes normally. err_clr pulse → err=00.
- Output backpressure: hold out_ready low 5 cycles, then toggle it every cycle → out_data/out_valid stable while stalled, no byte lost or duplicated.
- Timeout:
  - Stimulus: TIMEOUT=16, core never asserts done.
  - Required: err[1]=1 exactly 16 cycles after START, out_valid never asserted, state returns to CMD.
  - A late core_done arriving afterwards → ignored.
- Reset mid-frame: pulse rst after 3 operand bytes → in_ready=0 during rst. A fresh full frame afterwards produces correct operands with no stale bytes.

Source files
------------

// File: rtl/cordic_byte_framer_if.sv
// ---------------------------------------------------------------------------
// cordic_byte_framer_if
//
// Purpose: the two byte-wide valid/ready streams of the CORDIC byte framer.
//   The input stream carries command/operand bytes into the framer. The
//   output stream carries result bytes out of it.
//
// Signals:
//   in_data   [7:0]  input byte                       (host -> framer)
//   in_valid         input byte valid                 (host -> framer)
//   in_ready         framer accepts a byte this cycle (framer -> host)
//   out_data  [7:0]  output byte                      (framer -> host)
//   out_valid        output byte valid                (framer -> host)
//   out_ready        downstream accepts a byte        (host -> framer)
//
// Modports:
//   master : the host side (pin interface / testbench)
//   slave  : the framer side
// ---------------------------------------------------------------------------
interface cordic_byte_framer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/cordic_byte_framer.sv
// ---------------------------------------------------------------------------
// cordic_byte_framer
//
// Purpose: byte-serial framer between an 8-bit pin interface and an iterative
//   CORDIC core. A command byte (0x00 vectoring, 0x01 rotation) is followed by
//   little-endian X, Y (and Z in rotation mode) operand bytes. Once a frame is
//   complete the core is launched with a one-cycle start pulse. When the core
//   reports done, results A then B are streamed out LSB first. Bad commands and
//   core timeouts are reported in a sticky error register.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   bus (slave)          input/output byte streams (see cordic_byte_framer_if)
//   core_start           one-cycle launch pulse to the core
//   core_mode            0 = vectoring, 1 = rotation
//   core_x, core_y       assembled X / Y operands (IN_W bits)
//   core_z               assembled Z (Z_W bits), 0 in vectoring mode
//   core_done            core result valid, single cycle
//   core_a, core_b       core results, sampled on core_done
//   err[1:0]             sticky errors: bit0 bad command, bit1 core timeout
//   err_clr              clears err; wins over a same-cycle set
// ---------------------------------------------------------------------------
module cordic_byte_framer #(
  parameter int IN_W    = 16,
  parameter int Z_W     = 32,
  parameter int A_W     = 16,
  parameter int B_W     = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  cordic_byte_framer_if.slave   bus,
  output logic                  core_start,
  output logic                  core_mode,
  output logic [IN_W-1:0]       core_x,
  output logic [IN_W-1:0]       core_y,
  output logic [Z_W-1:0]        core_z,
  input  logic                  core_done,
  input  logic [A_W-1:0]        core_a,
  input  logic [B_W-1:0]        core_b,
  output logic [1:0]            err,
  input  logic                  err_clr
);

  localparam int OP_W     = 2 * IN_W + Z_W;
  localparam int OP_BYTES = OP_W / 8;
  localparam int RX_VEC   = 2 * IN_W / 8;
  localparam int RX_ROT   = RX_VEC + Z_W / 8;
  localparam int RES_W    = A_W + B_W;
  localparam int TX_N     = RES_W / 8;
  // One counter serves byte counting in RX/TX and cycle counting in WAIT.
  localparam int MAX_A    = (TIMEOUT > RX_ROT) ? TIMEOUT : RX_ROT;
  localparam int MAX_C    = (MAX_A > TX_N) ? MAX_A : TX_N;
  localparam int CNT_W    = $clog2(MAX_C + 1);

  typedef enum logic [2:0] {
    S_CMD,
    S_RX,
    S_START,
    S_WAIT,
    S_TX
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               mode_q;
  logic               start_q;
  logic [1:0]         err_q;
  logic [1:0]         err_d;
  logic [OP_W-1:0]    opnd_q;
  logic [OP_W-1:0]    opnd_d;
  logic [RES_W-1:0]   res_q;

  logic in_acc;
  logic out_acc;
  logic cmd_ok;
  logic cmd_start;
  logic bad_cmd;
  logic rx_last;
  logic tx_last;
  logic tmo_hit;

  // Stream outputs; everything is forced low while rst is asserted.
  assign bus.in_ready  = !rst && ((state_q == S_CMD) || (state_q == S_RX));
  assign bus.out_valid = !rst && (state_q == S_TX);
  assign bus.out_data  = bus.out_valid ? res_q[7:0] : 8'h00;

  assign in_acc    = bus.in_valid && bus.in_ready;
  assign out_acc   = bus.out_valid && bus.out_ready;

  assign cmd_ok    = (bus.in_data == 8'h00) || (bus.in_data == 8'h01);
  assign cmd_start = (state_q == S_CMD) && in_acc && cmd_ok;
  assign bad_cmd   = (state_q == S_CMD) && in_acc && !cmd_ok;

  assign rx_last   = (cnt_q == (mode_q ? CNT_W'(RX_ROT - 1) : CNT_W'(RX_VEC - 1)));
  assign tx_last   = (cnt_q == CNT_W'(TX_N - 1));
  // done in the final allowed WAIT cycle still wins over the timeout.
  assign tmo_hit   = (state_q == S_WAIT) && !core_done && (cnt_q == CNT_W'(TIMEOUT - 1));

  assign err_d     = err_clr ? 2'b00 : (err_q | {tmo_hit, bad_cmd});

  // Operand byte lanes: byte number cnt_q of the frame lands in lane cnt_q,
  // so X, Y, Z fill in order and each operand ends up little-endian. A new
  // command wipes the previous frame's operands.
  for (genvar gi = 0; gi < OP_BYTES; gi++) begin : g_lane
    logic lane_we;
    assign lane_we = (state_q == S_RX) && in_acc && (cnt_q == CNT_W'(gi));
    assign opnd_d[gi*8 +: 8] = cmd_start ? 8'h00 :
                               (lane_we ? bus.in_data : opnd_q[gi*8 +: 8]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CMD;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      start_q <= 1'b0;
      err_q   <= 2'b00;
      opnd_q  <= '0;
      res_q   <= '0;
    end else begin
      err_q   <= err_d;
      opnd_q  <= opnd_d;
      start_q <= 1'b0;
      case (state_q)
        S_CMD: begin
          if (cmd_start) begin
            mode_q  <= bus.in_data[0];
            cnt_q   <= '0;
            state_q <= S_RX;
          end
        end
        S_RX: begin
          if (in_acc) begin
            if (rx_last) begin
              cnt_q   <= '0;
              start_q <= 1'b1;   // registered pulse, high for the START cycle
              state_q <= S_START;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        S_START: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (core_done) begin
            // A in the low bits so the output shifter emits A first, LSB first.
            res_q   <= {core_b, core_a};
            cnt_q   <= '0;
            state_q <= S_TX;
          end else if (tmo_hit) begin
            cnt_q   <= '0;
            state_q <= S_CMD;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_TX: begin
          if (out_acc) begin
            res_q <= res_q >> 8;
            if (tx_last) begin
              cnt_q   <= '0;
              state_q <= S_CMD;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= S_CMD;
      endcase
    end
  end

  assign core_start = start_q && !rst;
  assign core_mode  = mode_q && !rst;
  assign core_x     = opnd_q[IN_W-1:0];
  assign core_y     = opnd_q[2*IN_W-1:IN_W];
  assign core_z     = mode_q ? opnd_q[OP_W-1:2*IN_W] : '0;
  assign err        = rst ? 2'b00 : err_q;

endmodule
